// File: rtl/mac_pkg.sv
// ============================================================================
// Package : mac_pkg
// Brief   : Shared lane codes, addresses, limits, tx state enum and CRC-32
//           constants for the MAC frame generator and checker.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  localparam logic [7:0]  c_IDLE_CODE     = 8'h07;
  localparam logic [7:0]  c_START_CODE    = 8'hFB;
  localparam logic [7:0]  c_TERM_CODE     = 8'hFD;
  localparam logic [7:0]  c_PREAMBLE_CODE = 8'h55;
  localparam logic [7:0]  c_SFD_CODE      = 8'hD5;
  localparam logic [47:0] c_DST_ADDR      = 48'h0180C2000001;
  localparam logic [47:0] c_SRC_ADDR      = 48'h5A5152535455;
  localparam int          c_MIN_PAYLOAD   = 46;
  localparam int          c_MAX_PAYLOAD   = 1500;
  localparam logic [31:0] c_CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] c_CRC32_INIT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_DATA     = 3'd3,
    ST_IFG      = 3'd4
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/mac_crc32_64.sv
// ============================================================================
// Module : mac_crc32_64
// Brief  : Reflected CRC-32 over the first i_nlanes byte lanes of a 64-bit word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_crc32_64
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_data,
  input  logic [3:0]  i_nlanes,
  input  logic        i_clear,
  input  logic        i_update,
  output logic [31:0] o_crc_next,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;
  logic [31:0] w_acc;

  // Lanes are consumed in wire order, LSB of each byte first.
  always_comb begin
    w_acc = r_crc;
    for (int l = 0; l < 8; l++) begin
      if (l < int'(i_nlanes)) begin
        w_acc = w_acc ^ {24'h0, 8'(i_data >> (8 * l))};
        for (int k = 0; k < 8; k++) begin
          w_acc = w_acc[0] ? ((w_acc >> 1) ^ c_CRC32_POLY) : (w_acc >> 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= c_CRC32_INIT;
    end else if (i_clear) begin
      r_crc <= c_CRC32_INIT;
    end else if (i_update) begin
      r_crc <= w_acc;
    end
  end

  assign o_crc_next = w_acc;
  assign o_crc      = r_crc;

endmodule

`default_nettype wire

// File: rtl/mac_frame_generator.sv
// ============================================================================
// Module : mac_frame_generator
// Brief  : Builds START/preamble/DA/SA/length/payload/FCS/TERM frames on a
//          64-bit data, 8-bit control TX lane interface.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_frame_generator
  import mac_pkg::*;
#(
  parameter int          DATA_WIDTH    = 64,
  parameter int          CTRL_WIDTH    = 8,
  parameter logic [7:0]  IDLE_CODE     = c_IDLE_CODE,
  parameter logic [7:0]  START_CODE    = c_START_CODE,
  parameter logic [7:0]  TERM_CODE     = c_TERM_CODE,
  parameter logic [7:0]  PREAMBLE_CODE = c_PREAMBLE_CODE,
  parameter logic [7:0]  SFD_CODE      = c_SFD_CODE,
  parameter logic [47:0] DST_ADDR_CODE = c_DST_ADDR,
  parameter logic [47:0] SRC_ADDR_CODE = c_SRC_ADDR,
  parameter int          MIN_PAYLOAD   = c_MIN_PAYLOAD,
  parameter int          MAX_PAYLOAD   = c_MAX_PAYLOAD,
  parameter int          IFG_WORDS     = 1
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [15:0]           i_payload_len,
  input  logic [7:0]            i_seed,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_len_error
);

  localparam logic [63:0] c_IDLE_WORD  = {8{IDLE_CODE}};
  localparam logic [63:0] c_START_WORD = {{7{IDLE_CODE}}, START_CODE};
  localparam logic [63:0] c_PRE_WORD   = {SFD_CODE, {7{PREAMBLE_CODE}}};

  tx_state_e   r_state;
  logic [15:0] r_len;
  logic [15:0] r_b;
  logic [7:0]  r_seed;
  logic [7:0]  r_ifg_cnt;
  logic        r_last;

  logic [15:0] w_data_end;
  logic [15:0] w_term_idx;
  logic [3:0]  w_nlanes;
  logic        w_len_ok;
  logic        w_gen;
  logic        w_has_term;
  logic [31:0] w_crc_next;
  logic [31:0] w_crc_reg;
  logic [31:0] w_fcs;
  logic [63:0] w_word_data;
  logic [7:0]  w_word_ctrl;
  logic [63:0] w_crc_din;

  function automatic logic [7:0] f_lane_byte(input logic [15:0] bi, input logic [15:0] len,
                                             input logic [7:0] seed, input logic [31:0] fcs);
    int idx;
    int n;
    idx = int'(bi);
    n   = int'(len);
    if (idx < 6)            f_lane_byte = 8'(DST_ADDR_CODE >> (8 * (5 - idx)));
    else if (idx < 12)      f_lane_byte = 8'(SRC_ADDR_CODE >> (8 * (11 - idx)));
    else if (idx == 12)     f_lane_byte = len[15:8];
    else if (idx == 13)     f_lane_byte = len[7:0];
    else if (idx < 14 + n)  f_lane_byte = seed + 8'(idx - 14);
    else if (idx < 18 + n)  f_lane_byte = 8'(fcs >> (8 * (idx - 14 - n)));
    else if (idx == 18 + n) f_lane_byte = TERM_CODE;
    else                    f_lane_byte = IDLE_CODE;
  endfunction

  assign w_data_end = r_len + 16'd14;
  assign w_term_idx = r_len + 16'd18;
  assign w_len_ok   = (i_payload_len >= 16'(MIN_PAYLOAD)) && (i_payload_len <= 16'(MAX_PAYLOAD));
  assign w_gen      = ((r_state == ST_PREAMBLE) || (r_state == ST_DATA)) && !r_last;
  assign w_has_term = (r_b <= w_term_idx) && (w_term_idx < r_b + 16'd8);

  always_comb begin
    w_nlanes = 4'd0;
    if (r_b < w_data_end) begin
      if ((w_data_end - r_b) >= 16'd8) w_nlanes = 4'd8;
      else                             w_nlanes = 4'(w_data_end - r_b);
    end
  end

  // FCS sharing a word with data bytes needs the CRC that already includes them.
  assign w_fcs = (w_nlanes != 4'd0) ? ~w_crc_next : ~w_crc_reg;

  for (genvar l = 0; l < 8; l++) begin : g_lane
    assign w_word_data[8*l +: 8] = f_lane_byte(r_b + 16'(l), r_len, r_seed, w_fcs);
    assign w_word_ctrl[l]        = (r_b + 16'(l)) >= w_term_idx;
    assign w_crc_din[8*l +: 8]   = f_lane_byte(r_b + 16'(l), r_len, r_seed, 32'h0);
  end

  mac_crc32_64 u_crc (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_data     (w_crc_din),
    .i_nlanes   (w_nlanes),
    .i_clear    (r_state == ST_START),
    .i_update   (w_gen),
    .o_crc_next (w_crc_next),
    .o_crc      (w_crc_reg)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_seed      <= '0;
      r_b         <= '0;
      r_ifg_cnt   <= '0;
      r_last      <= 1'b0;
      o_tx_data   <= c_IDLE_WORD;
      o_tx_ctrl   <= '1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_len_error <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_len_error <= 1'b0;
      case (r_state)
        ST_START: begin
          r_state   <= ST_PREAMBLE;
          o_tx_data <= c_PRE_WORD;
          o_tx_ctrl <= '0;
          r_b       <= '0;
          r_last    <= 1'b0;
        end
        ST_PREAMBLE, ST_DATA: begin
          if (r_last) begin
            // o_busy falls with the last IFG word so a held request restarts after exactly IFG_WORDS idles.
            r_state   <= ST_IFG;
            o_tx_data <= c_IDLE_WORD;
            o_tx_ctrl <= '1;
            r_ifg_cnt <= 8'(IFG_WORDS - 1);
            o_busy    <= (IFG_WORDS > 1);
          end else begin
            r_state   <= ST_DATA;
            o_tx_data <= w_word_data;
            o_tx_ctrl <= w_word_ctrl;
            r_b       <= r_b + 16'd8;
            r_last    <= w_has_term;
            o_done    <= w_has_term;
          end
        end
        default: begin
          o_tx_data <= c_IDLE_WORD;
          o_tx_ctrl <= '1;
          if ((r_state == ST_IFG) && (r_ifg_cnt != 8'd0)) begin
            r_ifg_cnt <= r_ifg_cnt - 8'd1;
            o_busy    <= (r_ifg_cnt != 8'd1);
          end else begin
            r_state <= ST_IDLE;
            if (i_start) begin
              if (w_len_ok) begin
                r_state   <= ST_START;
                r_len     <= i_payload_len;
                r_seed    <= i_seed;
                o_busy    <= 1'b1;
                o_tx_data <= c_START_WORD;
              end else begin
                o_len_error <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_frame_generator.sv
// ============================================================================
// Module : tb_mac_frame_generator
// Brief  : Directed self-checking bench for mac_frame_generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_frame_generator;

  logic        clk;
  logic        i_rst_n;
  logic        i_start;
  logic [15:0] i_payload_len;
  logic [7:0]  i_seed;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic        o_busy;
  logic        o_done;
  logic        o_len_error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fb       [0:1599];
  logic [63:0] cap_data [0:199];
  logic [7:0]  cap_ctrl [0:199];

  localparam logic [71:0] c_IDLE_W = {8'hFF, 64'h0707070707070707};

  mac_frame_generator dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_payload_len (i_payload_len),
    .i_seed        (i_seed),
    .o_tx_data     (o_tx_data),
    .o_tx_ctrl     (o_tx_ctrl),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_len_error   (o_len_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic busy_exp);
    chk({tag, "_word"}, {o_tx_ctrl, o_tx_data}, c_IDLE_W);
    chk({tag, "_busy"}, {71'd0, o_busy}, {71'd0, busy_exp});
    chk({tag, "_done"}, {71'd0, o_done}, 72'd0);
  endtask

  function automatic logic [31:0] crc32_model(input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Entered at the negedge showing the START word; returns at the negedge showing the TERM word.
  task automatic check_frame(input int n, input logic [7:0] seed);
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] nl;
    logic [31:0] fcs;
    logic [63:0] ed;
    logic [7:0]  ec;
    int          nw;
    int          b;
    da = 48'h0180C2000001;
    sa = 48'h5A5152535455;
    nl = 16'(n);
    for (int i = 0; i < 6; i++) begin
      fb[i]     = 8'(da >> (8 * (5 - i)));
      fb[6 + i] = 8'(sa >> (8 * (5 - i)));
    end
    fb[12] = nl[15:8];
    fb[13] = nl[7:0];
    for (int i = 0; i < n; i++) fb[14 + i] = seed + 8'(i);
    fcs = crc32_model(14 + n);
    for (int j = 0; j < 4; j++) fb[14 + n + j] = 8'(fcs >> (8 * j));
    nw = (19 + n + 7) / 8;
    chk($sformatf("n%0d_start", n), {o_tx_ctrl, o_tx_data}, {8'hFF, 56'h07070707070707, 8'hFB});
    chk($sformatf("n%0d_start_busy", n), {71'd0, o_busy}, 72'd1);
    @(negedge clk);
    chk($sformatf("n%0d_preamble", n), {o_tx_ctrl, o_tx_data}, {8'h00, 64'hD555555555555555});
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      ed = '0;
      ec = '0;
      for (int l = 0; l < 8; l++) begin
        b = 8 * w + l;
        if (b < 18 + n)       begin ed = {fb[b], ed[63:8]}; ec = {1'b0, ec[7:1]}; end
        else if (b == 18 + n) begin ed = {8'hFD, ed[63:8]}; ec = {1'b1, ec[7:1]}; end
        else                  begin ed = {8'h07, ed[63:8]}; ec = {1'b1, ec[7:1]}; end
      end
      cap_data[w] = o_tx_data;
      cap_ctrl[w] = o_tx_ctrl;
      chk($sformatf("n%0d_word%0d", n, w), {o_tx_ctrl, o_tx_data}, {ec, ed});
      chk($sformatf("n%0d_done%0d", n, w), {71'd0, o_done}, {71'd0, 1'(w == nw - 1)});
      chk($sformatf("n%0d_busy%0d", n, w), {71'd0, o_busy}, 72'd1);
    end
  endtask

  task automatic request(input int n, input logic [7:0] seed);
    i_start       = 1'b1;
    i_payload_len = 16'(n);
    i_seed        = seed;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic reject(input int n);
    request(n, 8'h00);
    chk($sformatf("n%0d_len_error", n), {71'd0, o_len_error}, 72'd1);
    chk_idle($sformatf("n%0d_rej", n), 1'b0);
    @(negedge clk);
    chk($sformatf("n%0d_len_error_clr", n), {71'd0, o_len_error}, 72'd0);
    chk_idle($sformatf("n%0d_rej_after", n), 1'b0);
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_start       = 1'b0;
    i_payload_len = '0;
    i_seed        = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset", 1'b0);
    chk("reset_len_error", {71'd0, o_len_error}, 72'd0);
    i_rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset", 1'b0);

    // Minimum frame: FCS in word 7 lanes 4-7, TERM alone in word 8
    request(46, 8'h00);
    check_frame(46, 8'h00);
    chk("n46_len_lanes", {56'd0, cap_data[1][39:32], cap_data[1][47:40]}, {56'd0, 16'h002E});
    chk("n46_w7_ctrl", {64'd0, cap_ctrl[7]}, 72'd0);
    chk("n46_term", {56'd0, cap_ctrl[8], cap_data[8][7:0]}, {56'd0, 8'hFF, 8'hFD});
    @(negedge clk);
    chk_idle("n46_ifg", 1'b0);

    // FCS spills into word 8; payload wraps FF -> 00
    request(47, 8'hF0);
    check_frame(47, 8'hF0);
    chk("n47_term", {56'd0, cap_ctrl[8], cap_data[8][15:8]}, {56'd0, 8'hFE, 8'hFD});
    chk("n47_wrap", {56'd0, cap_data[3][47:40], cap_data[3][55:48]}, {56'd0, 16'hFF00});
    @(negedge clk);
    chk_idle("n47_ifg", 1'b0);

    reject(45);
    reject(1501);

    // Held request: exactly one idle word between TERM and the next START
    i_start       = 1'b1;
    i_payload_len = 16'd46;
    i_seed        = 8'h11;
    @(negedge clk);
    check_frame(46, 8'h11);
    @(negedge clk);
    chk_idle("b2b_ifg", 1'b0);
    @(negedge clk);
    i_start = 1'b0;
    check_frame(46, 8'h11);
    @(negedge clk);
    chk_idle("b2b_ifg2", 1'b0);

    // Asynchronous reset in the middle of the payload
    request(100, 8'h03);
    repeat (6) @(negedge clk);
    chk("mid_busy", {71'd0, o_busy}, 72'd1);
    #2 i_rst_n = 1'b0;
    #1 chk_idle("mid_reset", 1'b0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset_after", 1'b0);
    request(64, 8'h77);
    check_frame(64, 8'h77);
    @(negedge clk);
    chk_idle("n64_ifg", 1'b0);

    // Maximum frame: 190 DATA words, TERM at word 189 lane 6
    request(1500, 8'h5A);
    check_frame(1500, 8'h5A);
    chk("n1500_term", {56'd0, cap_ctrl[189], cap_data[189][55:48]}, {56'd0, 8'hC0, 8'hFD});
    @(negedge clk);
    chk_idle("n1500_ifg", 1'b0);
    @(negedge clk);
    chk_idle("n1500_idle", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
